// File: rtl/ipm_frame_reader.sv
// VGA raster reader for the IPM double-buffered frame store: generates 640x480 timing,
// reads the display bank in raster order and swaps banks at vsync start once a frame is ready.
module ipm_frame_reader #(
   parameter int unsigned CAM_DATA_WIDTH = 12,
   parameter int unsigned CAM_LINE       = 9,
   parameter int unsigned CAM_PIXEL      = 10,
   parameter int unsigned CLK_DIV        = 4,
   parameter int unsigned H_ACTIVE       = 640,
   parameter int unsigned H_FP           = 16,
   parameter int unsigned H_SYNC         = 96,
   parameter int unsigned H_BP           = 48,
   parameter int unsigned V_ACTIVE       = 480,
   parameter int unsigned V_FP           = 10,
   parameter int unsigned V_SYNC         = 2,
   parameter int unsigned V_BP           = 33
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_frame_done,
   output logic                          o_rd_buf,
   output logic                          o_wr_buf,
   output logic [CAM_LINE+CAM_PIXEL-1:0] o_rd_addr,
   input  logic [CAM_DATA_WIDTH-1:0]     i_rd_data,
   output logic [3:0]                    o_red,
   output logic [3:0]                    o_green,
   output logic [3:0]                    o_blue,
   output logic                          o_hsync,
   output logic                          o_vsync,
   output logic                          o_de,
   output logic                          o_frame_start
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
   localparam int unsigned HW       = $clog2(H_TOTAL);
   localparam int unsigned VW       = $clog2(V_TOTAL);
   localparam int unsigned DW       = $clog2(CLK_DIV);
   localparam int unsigned AW       = CAM_LINE + CAM_PIXEL;

   logic [DW-1:0] div_q, div_d;
   logic [HW-1:0] h_q, h_d, next_h;
   logic [VW-1:0] v_q, v_d, next_v;
   logic [AW-1:0] addr_q, addr_d;
   logic [3:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic          de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic          fs_q, fs_d, pending_q, pending_d;
   logic          rd_buf_q, rd_buf_d, wr_buf_q, wr_buf_d;
   logic          tick, cur_active, next_active, swap_pt;

   // Pixel-tick divider and raster position after this tick
   always_comb begin
      tick   = (div_q == DW'(CLK_DIV - 1));
      div_d  = tick ? '0 : div_q + DW'(1);
      next_h = (h_q == HW'(H_TOTAL - 1)) ? '0 : h_q + HW'(1);
      next_v = v_q;
      if (h_q == HW'(H_TOTAL - 1)) begin
         next_v = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
      end
      cur_active  = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
      next_active = (next_h < HW'(H_ACTIVE)) && (next_v < VW'(V_ACTIVE));
   end

   // Counters, prefetch address and output stage; outputs lag the counters by one tick
   always_comb begin
      h_d     = h_q;
      v_d     = v_q;
      addr_d  = addr_q;
      red_d   = red_q;
      green_d = green_q;
      blue_d  = blue_q;
      de_d    = de_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      fs_d    = tick && (h_q == '0) && (v_q == '0);
      if (tick) begin
         h_d = next_h;
         v_d = next_v;
         if (next_active) begin
            addr_d = {CAM_LINE'(next_v), CAM_PIXEL'(next_h)};
         end
         de_d    = cur_active;
         red_d   = cur_active ? i_rd_data[11:8] : 4'h0;
         green_d = cur_active ? i_rd_data[7:4]  : 4'h0;
         blue_d  = cur_active ? i_rd_data[3:0]  : 4'h0;
         hsync_d = ~((h_q >= HW'(HS_START)) && (h_q <= HW'(HS_END)));
         vsync_d = ~((v_q >= VW'(VS_START)) && (v_q <= VW'(VS_END)));
      end
   end

   // Bank swap only at vsync start; a done pulse coincident with a swap stays recorded
   always_comb begin
      swap_pt   = tick && (h_q == '0) && (v_q == VW'(VS_START));
      pending_d = pending_q;
      rd_buf_d  = rd_buf_q;
      wr_buf_d  = wr_buf_q;
      if (swap_pt && pending_q) begin
         rd_buf_d  = ~rd_buf_q;
         wr_buf_d  = rd_buf_q;
         pending_d = 1'b0;
      end
      if (i_frame_done) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q     <= '0;
         h_q       <= '0;
         v_q       <= '0;
         addr_q    <= '0;
         red_q     <= 4'h0;
         green_q   <= 4'h0;
         blue_q    <= 4'h0;
         de_q      <= 1'b0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         fs_q      <= 1'b0;
         pending_q <= 1'b0;
         rd_buf_q  <= 1'b0;
         wr_buf_q  <= 1'b1;
      end else begin
         div_q     <= div_d;
         h_q       <= h_d;
         v_q       <= v_d;
         addr_q    <= addr_d;
         red_q     <= red_d;
         green_q   <= green_d;
         blue_q    <= blue_d;
         de_q      <= de_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         fs_q      <= fs_d;
         pending_q <= pending_d;
         rd_buf_q  <= rd_buf_d;
         wr_buf_q  <= wr_buf_d;
      end
   end

   assign o_rd_addr     = addr_q;
   assign o_red         = red_q;
   assign o_green       = green_q;
   assign o_blue        = blue_q;
   assign o_de          = de_q;
   assign o_hsync       = hsync_q;
   assign o_vsync       = vsync_q;
   assign o_frame_start = fs_q;
   assign o_rd_buf      = rd_buf_q;
   assign o_wr_buf      = wr_buf_q;

endmodule
